// File: rtl/predictor_update_queue.sv
// Predictor update queue: buffers table writes until the table write port is free,
// merging repeat updates to the youngest index and forwarding queued values to lookups.
module predictor_update_queue #(
  parameter int ENTRY_NUM     = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 2,
  parameter int PUSH_PORT_NUM = 2,
  parameter int COALESCE      = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PUSH_PORT_NUM-1:0]            pushValid,
  input  logic [PUSH_PORT_NUM*ADDR_WIDTH-1:0] pushAddr,
  input  logic [PUSH_PORT_NUM*DATA_WIDTH-1:0] pushData,
  output logic                                full,
  input  logic                                drainEnable,
  output logic                                drainValid,
  output logic [ADDR_WIDTH-1:0]               drainAddr,
  output logic [DATA_WIDTH-1:0]               drainData,
  input  logic [ADDR_WIDTH-1:0]               lookupAddr,
  output logic                                lookupHit,
  output logic [DATA_WIDTH-1:0]               lookupData,
  output logic [$clog2(ENTRY_NUM+1)-1:0]      count,
  output logic                                overflow
);

  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = $clog2(ENTRY_NUM + 1);
  localparam int SPC_W = CNT_W + 1;

  logic [ADDR_WIDTH-1:0] addrMem [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] dataMem [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]  validBits;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  // Ports widened to two lanes so a single-port build needs no special casing.
  logic [1:0]            pValid;
  logic [ADDR_WIDTH-1:0] pAddr [2];
  logic [DATA_WIDTH-1:0] pData [2];

  logic                  pop;
  logic [PTR_W-1:0]      youngIdx;
  logic                  youngMergeable;
  logic [SPC_W-1:0]      space;
  logic                  merge0;
  logic                  alloc0;
  logic                  drop0;
  logic                  merge1;
  logic                  alloc1;
  logic                  drop1;
  logic [PTR_W-1:0]      slot1;
  logic [PTR_W-1:0]      merge1Idx;
  logic [PTR_W-1:0]      probeIdx;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pValid   = '0;
    pAddr[0] = '0;
    pAddr[1] = '0;
    pData[0] = '0;
    pData[1] = '0;
    for (int p = 0; p < PUSH_PORT_NUM; p++) begin
      pValid[p] = pushValid[p];
      pAddr[p]  = pushAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      pData[p]  = pushData[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign drainValid = (count != '0);
  assign drainAddr  = addrMem[head];
  assign drainData  = dataMem[head];
  assign full       = (CNT_W'(ENTRY_NUM) - count) < CNT_W'(PUSH_PORT_NUM);
  assign pop        = drainValid && drainEnable;

  // The youngest entry can absorb a push unless it is also the head leaving this cycle.
  assign youngIdx       = tail - PTR_W'(1);
  assign youngMergeable = (COALESCE != 0) && drainValid && !(pop && count == CNT_W'(1));

  // Free slots this cycle, counting the slot released by a same-cycle pop.
  assign space = SPC_W'(ENTRY_NUM) - SPC_W'(count) + SPC_W'(pop);

  always_comb begin
    merge0 = pValid[0] && youngMergeable && (addrMem[youngIdx] == pAddr[0]);
    alloc0 = pValid[0] && !merge0 && (space != '0);
    drop0  = pValid[0] && !merge0 && !alloc0;

    // Port 1 sees port 0's new entry as the youngest whenever port 0 allocated.
    merge1 = 1'b0;
    if (pValid[1] && COALESCE != 0) begin
      if (alloc0) merge1 = (pAddr[1] == pAddr[0]);
      else        merge1 = youngMergeable && (addrMem[youngIdx] == pAddr[1]);
    end
    alloc1 = pValid[1] && !merge1 && (space > SPC_W'(alloc0));
    drop1  = pValid[1] && !merge1 && !alloc1;

    slot1     = tail + PTR_W'(alloc0);
    merge1Idx = alloc0 ? tail : youngIdx;
  end

  // NOTE: payload storage has no reset; the valid bits and count alone decide what is live.
  always_ff @(posedge clk) begin
    if (merge0) dataMem[youngIdx] <= pData[0];
    if (alloc0) begin
      addrMem[tail] <= pAddr[0];
      dataMem[tail] <= pData[0];
    end
    // NOTE: several non-blocking writes may hit one slot; the last in program order wins,
    // which gives port 1 priority over port 0 on a merged pair.
    if (merge1) dataMem[merge1Idx] <= pData[1];
    if (alloc1) begin
      addrMem[slot1] <= pAddr[1];
      dataMem[slot1] <= pData[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      validBits <= '0;
      overflow  <= 1'b0;
    end else begin
      // Clear before set: a full queue can pop and refill the same slot in one cycle.
      if (pop)    validBits[head]  <= 1'b0;
      if (alloc0) validBits[tail]  <= 1'b1;
      if (alloc1) validBits[slot1] <= 1'b1;
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(alloc0) + PTR_W'(alloc1);
      count <= count + CNT_W'(alloc0) + CNT_W'(alloc1) - CNT_W'(pop);
      if (drop0 || drop1) overflow <= 1'b1;
    end
  end

  // Walk from head toward tail so a later match overrides an older one.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    probeIdx   = head;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      probeIdx = head + PTR_W'(i);
      if (validBits[probeIdx] && addrMem[probeIdx] == lookupAddr) begin
        lookupHit  = 1'b1;
        lookupData = dataMem[probeIdx];
      end
    end
  end

endmodule

// File: tb/tb_predictor_update_queue.sv
// Self-checking bench: a coalescing and a non-coalescing queue driven in lockstep,
// each compared against an ordered-list reference model every cycle.
module tb_predictor_update_queue;

  localparam int ENTRIES = 32;

  logic        clk;
  logic        rst;
  logic [1:0]  pushValid;
  logic [19:0] pushAddr;
  logic [3:0]  pushData;
  logic        drainEnable;
  logic [9:0]  lookupAddr;

  logic       dFull       [2];
  logic       dDrainValid [2];
  logic [9:0] dDrainAddr  [2];
  logic [1:0] dDrainData  [2];
  logic       dHit        [2];
  logic [1:0] dLookData   [2];
  logic [5:0] dCount      [2];
  logic       dOverflow   [2];

  int compared;
  int mismatched;

  // Reference model: index 0 is the oldest entry; model 0 coalesces, model 1 does not.
  logic [9:0] mAddr [2][ENTRIES+2];
  logic [1:0] mData [2][ENTRIES+2];
  int         mLen  [2];
  bit         mOvf  [2];

  predictor_update_queue #(.ENTRY_NUM(ENTRIES), .COALESCE(1)) dutCo (
    .clk(clk), .rst(rst), .pushValid(pushValid), .pushAddr(pushAddr), .pushData(pushData),
    .full(dFull[0]), .drainEnable(drainEnable), .drainValid(dDrainValid[0]),
    .drainAddr(dDrainAddr[0]), .drainData(dDrainData[0]), .lookupAddr(lookupAddr),
    .lookupHit(dHit[0]), .lookupData(dLookData[0]), .count(dCount[0]), .overflow(dOverflow[0])
  );

  predictor_update_queue #(.ENTRY_NUM(ENTRIES), .COALESCE(0)) dutNc (
    .clk(clk), .rst(rst), .pushValid(pushValid), .pushAddr(pushAddr), .pushData(pushData),
    .full(dFull[1]), .drainEnable(drainEnable), .drainValid(dDrainValid[1]),
    .drainAddr(dDrainAddr[1]), .drainData(dDrainData[1]), .lookupAddr(lookupAddr),
    .lookupHit(dHit[1]), .lookupData(dLookData[1]), .count(dCount[1]), .overflow(dOverflow[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string tagOf(input string ph, input int m, input string name);
    return $sformatf("%s.%s.%s", ph, (m == 0) ? "co" : "nc", name);
  endfunction

  task automatic resetModel();
    for (int m = 0; m < 2; m++) begin
      mLen[m] = 0;
      mOvf[m] = 1'b0;
    end
  endtask

  // Apply one clock edge worth of the current inputs: pushes in port order, then the pop.
  task automatic modelStep();
    for (int m = 0; m < 2; m++) begin
      bit popNow;
      int len;
      popNow = (mLen[m] != 0) && drainEnable;
      len    = mLen[m];
      for (int p = 0; p < 2; p++) begin
        if (pushValid[p]) begin
          logic [9:0] a;
          logic [1:0] d;
          a = pushAddr[p*10 +: 10];
          d = pushData[p*2 +: 2];
          if (m == 0 && len > 0 && mAddr[m][len-1] == a && !(popNow && len == 1)) begin
            mData[m][len-1] = d;
          end else if (len - int'(popNow) < ENTRIES) begin
            mAddr[m][len] = a;
            mData[m][len] = d;
            len++;
          end else begin
            mOvf[m] = 1'b1;
          end
        end
      end
      if (popNow) begin
        for (int i = 0; i < len - 1; i++) begin
          mAddr[m][i] = mAddr[m][i+1];
          mData[m][i] = mData[m][i+1];
        end
        len--;
      end
      mLen[m] = len;
    end
  endtask

  task automatic checkAll(input string ph);
    for (int m = 0; m < 2; m++) begin
      bit         eHit;
      logic [1:0] eData;
      eHit  = 1'b0;
      eData = 2'd0;
      for (int i = 0; i < mLen[m]; i++) begin
        if (mAddr[m][i] == lookupAddr) begin
          eHit  = 1'b1;
          eData = mData[m][i];
        end
      end
      check(tagOf(ph, m, "count"), 32'(dCount[m]), 32'(mLen[m]));
      check(tagOf(ph, m, "drainValid"), 32'(dDrainValid[m]), 32'(mLen[m] != 0));
      check(tagOf(ph, m, "full"), 32'(dFull[m]), 32'((ENTRIES - mLen[m]) < 2));
      check(tagOf(ph, m, "overflow"), 32'(dOverflow[m]), 32'(mOvf[m]));
      check(tagOf(ph, m, "lookupHit"), 32'(dHit[m]), 32'(eHit));
      check(tagOf(ph, m, "lookupData"), 32'(dLookData[m]), 32'(eData));
      if (mLen[m] != 0) begin
        check(tagOf(ph, m, "drainAddr"), 32'(dDrainAddr[m]), 32'(mAddr[m][0]));
        check(tagOf(ph, m, "drainData"), 32'(dDrainData[m]), 32'(mData[m][0]));
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step(input string ph);
    #1;
    checkAll(ph);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic setPush(input logic v0, input logic [9:0] a0, input logic [1:0] d0,
                         input logic v1, input logic [9:0] a1, input logic [1:0] d1);
    pushValid = {v1, v0};
    pushAddr  = {a1, a0};
    pushData  = {d1, d0};
  endtask

  // Asynchronous reset pulse placed between clock edges; starts and ends at a falling edge.
  task automatic pulseReset(input string ph);
    #2 rst = 1'b1;
    #1;
    resetModel();
    for (int m = 0; m < 2; m++) begin
      check(tagOf(ph, m, "rstCount"), 32'(dCount[m]), 32'd0);
      check(tagOf(ph, m, "rstDrainValid"), 32'(dDrainValid[m]), 32'd0);
      check(tagOf(ph, m, "rstOverflow"), 32'(dOverflow[m]), 32'd0);
      check(tagOf(ph, m, "rstFull"), 32'(dFull[m]), 32'd0);
      check(tagOf(ph, m, "rstHit"), 32'(dHit[m]), 32'd0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    drainEnable = 1'b0;
    lookupAddr  = 10'h000;
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    resetModel();

    // Reset state.
    #1;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic FIFO order with drain held off, then released.
    setPush(1'b1, 10'h005, 2'd2, 1'b1, 10'h006, 2'd1);
    lookupAddr = 10'h006;
    step("fifoPush");
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    check("fifo.count", 32'(dCount[0]), 32'd2);
    check("fifo.drainAddr", 32'(dDrainAddr[0]), 32'h005);
    check("fifo.drainData", 32'(dDrainData[0]), 32'd2);
    drainEnable = 1'b1;
    step("fifoDrain0");
    check("fifo.drainAddr2", 32'(dDrainAddr[0]), 32'h006);
    step("fifoDrain1");
    drainEnable = 1'b0;
    check("fifo.countEmpty", 32'(dCount[0]), 32'd0);

    // Back-to-back pushes of one index: merged only on the coalescing queue.
    setPush(1'b1, 10'h010, 2'd1, 1'b0, 10'h0, 2'd0);
    lookupAddr = 10'h010;
    step("coPush0");
    setPush(1'b1, 10'h010, 2'd3, 1'b0, 10'h0, 2'd0);
    step("coPush1");
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    check("co.count", 32'(dCount[0]), 32'd1);
    check("co.hit", 32'(dHit[0]), 32'd1);
    check("co.lookupData", 32'(dLookData[0]), 32'd3);
    check("nc.count", 32'(dCount[1]), 32'd2);
    check("nc.lookupData", 32'(dLookData[1]), 32'd3);
    drainEnable = 1'b1;
    for (int i = 0; i < 3; i++) step("coDrain");
    drainEnable = 1'b0;

    // Both ports push the same index in one cycle into an empty queue.
    setPush(1'b1, 10'h020, 2'd0, 1'b1, 10'h020, 2'd3);
    lookupAddr = 10'h020;
    step("dupPush");
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    check("dup.co.count", 32'(dCount[0]), 32'd1);
    check("dup.co.drainData", 32'(dDrainData[0]), 32'd3);
    check("dup.nc.count", 32'(dCount[1]), 32'd2);
    check("dup.nc.drainData", 32'(dDrainData[1]), 32'd0);
    drainEnable = 1'b1;
    for (int i = 0; i < 3; i++) step("dupDrain");
    drainEnable = 1'b0;

    // Fill to 31 with distinct indices, then overflow with and without a pop.
    lookupAddr = 10'h105;
    for (int i = 0; i < 15; i++) begin
      setPush(1'b1, 10'(10'h100 + 2*i), 2'(i), 1'b1, 10'(10'h101 + 2*i), 2'(i + 1));
      step("fill");
    end
    setPush(1'b1, 10'h11E, 2'd1, 1'b0, 10'h0, 2'd0);
    step("fillLast");
    check("fill.count31", 32'(dCount[0]), 32'd31);
    check("fill.full", 32'(dFull[0]), 32'd1);
    setPush(1'b1, 10'h200, 2'd2, 1'b1, 10'h201, 2'd3);
    step("ovfPush");
    check("ovf.count32", 32'(dCount[0]), 32'd32);
    check("ovf.flag", 32'(dOverflow[0]), 32'd1);
    setPush(1'b1, 10'h202, 2'd1, 1'b1, 10'h203, 2'd2);
    drainEnable = 1'b1;
    step("ovfPushPop");
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    drainEnable = 1'b0;
    check("ovf.countStays32", 32'(dCount[0]), 32'd32);
    check("ovf.sticky", 32'(dOverflow[0]), 32'd1);
    step("ovfIdle");
    pulseReset("rstFull");

    // Five entries queued, then an asynchronous reset between edges.
    setPush(1'b1, 10'h301, 2'd1, 1'b1, 10'h302, 2'd2);
    step("pre5a");
    setPush(1'b1, 10'h303, 2'd3, 1'b1, 10'h304, 2'd0);
    step("pre5b");
    setPush(1'b1, 10'h305, 2'd1, 1'b0, 10'h0, 2'd0);
    step("pre5c");
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    check("pre5.count", 32'(dCount[0]), 32'd5);
    pulseReset("rst5");
    setPush(1'b1, 10'h3AB, 2'd2, 1'b0, 10'h0, 2'd0);
    lookupAddr = 10'h3AB;
    step("postRst");
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    check("postRst.count", 32'(dCount[0]), 32'd1);
    check("postRst.drainAddr", 32'(dDrainAddr[0]), 32'h3AB);
    check("postRst.drainData", 32'(dDrainData[0]), 32'd2);
    drainEnable = 1'b1;
    step("postRstDrain");

    // Steady push+pop across several pointer wraps; the first cycle pushes into an empty queue.
    for (int i = 0; i < 100; i++) begin
      setPush(1'b1, 10'(10'h040 + i), 2'(i), 1'b0, 10'h0, 2'd0);
      lookupAddr = 10'(10'h040 + i);
      step("wrap");
      check("wrap.countStable", 32'(dCount[0]), 32'd1);
    end
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    step("wrapDrain");

    // Random traffic over a small index pool so merges, lookups and overflow all occur.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      setPush(v[0], 10'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
              v[1], 10'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
      drainEnable = ($urandom_range(0, 99) < ((i < 200) ? 35 : 80));
      lookupAddr  = 10'($urandom_range(0, 6));
      step("rand");
    end
    setPush(1'b0, 10'h0, 2'd0, 1'b0, 10'h0, 2'd0);
    drainEnable = 1'b0;
    #1;
    checkAll("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/predictor_update_queue.md
PREDICTOR_UPDATE_QUEUE -- requirements
Module: predictor_update_queue

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ENTRY_NUM, 32: queue depth; power of two, 4..64.
- ADDR_WIDTH, 10: table index width.
- DATA_WIDTH, 2: table entry width.
- PUSH_PORT_NUM, 2: enqueue ports, 1..2.
- COALESCE, 1: 1 = merge a push into a matching youngest entry.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-high reset.
- pushValid, in, PUSH_PORT_NUM: per-port enqueue request; port 1 is younger than port 0.
- pushAddr, in, PUSH_PORT_NUM x ADDR_WIDTH: table index per port.
- pushData, in, PUSH_PORT_NUM x DATA_WIDTH: new entry value per port.
- full, out, 1: free slots < PUSH_PORT_NUM.
- drainEnable, in, 1: table write port is free this cycle.
- drainValid, out, 1: head entry is presented.
- drainAddr, out, ADDR_WIDTH: head entry index.
- drainData, out, DATA_WIDTH: head entry value.
- lookupAddr, in, ADDR_WIDTH: forwarding probe.
- lookupHit, out, 1: a queued entry matches lookupAddr.
- lookupData, out, DATA_WIDTH: value of the youngest matching entry.
- count, out, $clog2(ENTRY_NUM+1): number of valid entries.
- overflow, out, 1: sticky flag; a push was dropped.

Function
REQ-003 Storage SHALL be a circular buffer with head and tail pointers of $clog2(ENTRY_NUM) bits that wrap modulo ENTRY_NUM, plus a per-entry valid bit.
REQ-004 drainValid SHALL equal (count != 0); drainAddr and drainData SHALL come combinationally from the head entry.
REQ-005 A pop SHALL occur at the clock edge when drainValid && drainEnable: the head entry is invalidated, head increments, and count decrements.
REQ-006 Valid pushes SHALL be handled in port order (0 then 1), each allocating at tail and incrementing tail; the data is visible on the drain/lookup outputs from the next cycle, with no same-cycle bypass.
REQ-007 With COALESCE=1, a push SHALL overwrite the data of the youngest valid entry (tail-1) instead of allocating, when all of the following hold:
- its addr equals that entry's addr;
- that entry is not being popped in the same cycle.
REQ-008 With COALESCE=1, when both ports push the same address in one cycle, the pair SHALL consume at most one entry, holding port 1's data (it also merges with tail-1 per REQ-007).
REQ-009 The capacity check SHALL use the count at the start of the cycle plus the same-cycle pop (a pop frees one slot for the same-cycle push).
- A push that would exceed ENTRY_NUM SHALL be dropped and SHALL set overflow.
- Port 0 SHALL be accepted before port 1.
REQ-010 count SHALL update as count + allocations - pop and SHALL never exceed ENTRY_NUM.
REQ-011 full SHALL be registered-state derived: (ENTRY_NUM - count) < PUSH_PORT_NUM.
REQ-012 Lookup SHALL be combinational: it searches all valid entries and returns the youngest match by age from head; lookupData SHALL be 0 when lookupHit=0.
REQ-013 overflow SHALL remain 1 until reset.
REQ-014 Simultaneous push and pop on an empty queue SHALL not pop (drainValid=0) and SHALL enqueue normally.

Reset
REQ-015 While rst=1 (asynchronously), the block SHALL hold:
- head=0, tail=0, count=0;
- all valid bits=0, overflow=0;
- hence drainValid=0, lookupHit=0, full=0.
REQ-016 Reset mid-operation SHALL discard all pending entries; entry data contents need not be cleared.

Verification
REQ-017 Basic FIFO: push (0x005,2), (0x006,1) on ports 0/1 in one cycle, drainEnable=0; next cycle count=2, drainAddr=0x005, drainData=2. Raise drainEnable for 2 cycles -> drains 0x005 then 0x006, count=0.
REQ-018 Coalesce: push 0x010/data 1, then next cycle 0x010/data 3 -> count=1, lookupAddr=0x010 gives hit with data 3. With COALESCE=0 the same stimulus -> count=2, lookup data 3.
REQ-019 Same-cycle duplicate: both ports push 0x020 (data 0, data 3) into an empty queue -> count=1, drainData=3.
REQ-020 Full/overflow: ENTRY_NUM=32, fill to 31; full=1. Push 2 with no pop -> one accepted, count=32, overflow=1. Repeat the push with drainEnable=1 -> one accepted, count stays 32.
REQ-021 Wrap-around: run 100 push/pop cycles with changing addresses -> drain order matches push order across pointer wrap and count is stable.
REQ-022 Reset: with 5 entries queued, pulse rst asynchronously between edges -> count=0 and drainValid=0 immediately, overflow=0; the next push appears at the old slot 0.
